// File: rtl/can_fault_confinement_if.sv
// rtl/can_fault_confinement_if.sv - event inputs and counter/state outputs of the fault-confinement block
interface can_fault_confinement_if;
    logic       reset_mode;
    logic       sample_point;
    logic       sampled_bit;
    logic       tx_error;
    logic       tx_ok;
    logic       rx_error;
    logic       rx_error_dom;
    logic       rx_ok;
    logic [8:0] tec;
    logic [7:0] rec;
    logic       node_error_passive;
    logic       node_bus_off;
    logic       error_warning;
    logic       state_change;

    modport master (
        output reset_mode, sample_point, sampled_bit,
        output tx_error, tx_ok, rx_error, rx_error_dom, rx_ok,
        input  tec, rec, node_error_passive, node_bus_off, error_warning, state_change
    );

    modport slave (
        input  reset_mode, sample_point, sampled_bit,
        input  tx_error, tx_ok, rx_error, rx_error_dom, rx_ok,
        output tec, rec, node_error_passive, node_bus_off, error_warning, state_change
    );
endinterface

// File: rtl/can_fault_confinement.sv
// rtl/can_fault_confinement.sv - CAN TEC/REC counters, node state tracking and bus-off recovery
module can_fault_confinement #(
    parameter int WARN_LIMIT        = 96,
    parameter int PASSIVE_LIMIT     = 127,
    parameter int RECESSIVE_SEQ_LEN = 11,
    parameter int RECOVERY_SEQ_CNT  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    can_fault_confinement_if.slave bus
);
    typedef enum logic [1:0] {
        ERROR_ACTIVE  = 2'b00,
        ERROR_PASSIVE = 2'b01,
        BUS_OFF       = 2'b10
    } state_t;

    localparam logic [8:0] TEC_WARN = 9'(WARN_LIMIT);
    localparam logic [7:0] REC_WARN = 8'(WARN_LIMIT);
    localparam logic [8:0] TEC_PASS = 9'(PASSIVE_LIMIT);
    localparam logic [7:0] REC_PASS = 8'(PASSIVE_LIMIT);
    localparam logic [3:0] BIT_LEN  = 4'(RECESSIVE_SEQ_LEN);
    localparam logic [7:0] SEQ_LEN  = 8'(RECOVERY_SEQ_CNT);

    state_t     r_state, w_state_nxt;
    logic [8:0] r_tec, w_tec_nxt;
    logic [7:0] r_rec, w_rec_nxt;
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_seq_cnt, w_seq_cnt_nxt;
    logic       r_warning, r_state_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ERROR_ACTIVE;
            r_tec          <= '0;
            r_rec          <= '0;
            r_bit_cnt      <= '0;
            r_seq_cnt      <= '0;
            r_warning      <= 1'b0;
            r_state_change <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tec          <= w_tec_nxt;
            r_rec          <= w_rec_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_seq_cnt      <= w_seq_cnt_nxt;
            r_warning      <= (w_tec_nxt >= TEC_WARN) || (w_rec_nxt >= REC_WARN);
            r_state_change <= (w_state_nxt != r_state);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tec_nxt     = r_tec;
        w_rec_nxt     = r_rec;
        w_bit_cnt_nxt = '0;
        w_seq_cnt_nxt = '0;
        if (bus.reset_mode) begin
            w_state_nxt = ERROR_ACTIVE;
            w_tec_nxt   = '0;
            w_rec_nxt   = '0;
        end else if (r_state == BUS_OFF) begin
            // Events are ignored; only recessive-bit sequences can bring the node back.
            w_bit_cnt_nxt = r_bit_cnt;
            w_seq_cnt_nxt = r_seq_cnt;
            if (bus.sample_point) begin
                if (!bus.sampled_bit) begin
                    w_bit_cnt_nxt = '0;
                end else if (r_bit_cnt + 4'd1 == BIT_LEN) begin
                    w_bit_cnt_nxt = '0;
                    if (r_seq_cnt + 8'd1 == SEQ_LEN) begin
                        w_seq_cnt_nxt = '0;
                        w_tec_nxt     = '0;
                        w_rec_nxt     = '0;
                        w_state_nxt   = ERROR_ACTIVE;
                    end else begin
                        w_seq_cnt_nxt = r_seq_cnt + 8'd1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                end
            end
        end else begin
            if (bus.tx_error)
                w_tec_nxt = (r_tec > 9'd503) ? 9'd511 : r_tec + 9'd8;
            else if (bus.tx_ok && r_tec != 9'd0)
                w_tec_nxt = r_tec - 9'd1;

            if (bus.rx_error_dom)
                w_rec_nxt = (r_rec > 8'd247) ? 8'd255 : r_rec + 8'd8;
            else if (bus.rx_error)
                w_rec_nxt = (r_rec == 8'd255) ? 8'd255 : r_rec + 8'd1;
            else if (bus.rx_ok) begin
                if (r_rec > 8'd127)
                    w_rec_nxt = 8'd119;
                else if (r_rec != 8'd0)
                    w_rec_nxt = r_rec - 8'd1;
            end

            // State follows the updated counters so counters and state never disagree.
            if (w_tec_nxt > 9'd255)
                w_state_nxt = BUS_OFF;
            else if (w_tec_nxt > TEC_PASS || w_rec_nxt > REC_PASS)
                w_state_nxt = ERROR_PASSIVE;
            else
                w_state_nxt = ERROR_ACTIVE;
        end
    end

    assign bus.tec                = r_tec;
    assign bus.rec                = r_rec;
    assign bus.node_error_passive = (r_state != ERROR_ACTIVE);
    assign bus.node_bus_off       = (r_state == BUS_OFF);
    assign bus.error_warning      = r_warning;
    assign bus.state_change       = r_state_change;
endmodule

// File: tb/tb_can_fault_confinement.sv
// tb/tb_can_fault_confinement.sv - directed self-checking bench for can_fault_confinement
module tb_can_fault_confinement;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    can_fault_confinement_if bus();

    can_fault_confinement dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic txe, input logic txo, input logic rxe,
                         input logic rxd, input logic rxo, input logic rm);
        bus.tx_error     = txe;
        bus.tx_ok        = txo;
        bus.rx_error     = rxe;
        bus.rx_error_dom = rxd;
        bus.rx_ok        = rxo;
        bus.reset_mode   = rm;
        tick();
        bus.tx_error     = 1'b0;
        bus.tx_ok        = 1'b0;
        bus.rx_error     = 1'b0;
        bus.rx_error_dom = 1'b0;
        bus.rx_ok        = 1'b0;
        bus.reset_mode   = 1'b0;
    endtask

    task automatic tx_errors(input int n);
        for (int i = 0; i < n; i++) pulse(1, 0, 0, 0, 0, 0);
    endtask

    task automatic samples(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            bus.sample_point = 1'b1;
            bus.sampled_bit  = b;
            tick();
        end
        bus.sample_point = 1'b0;
        bus.sampled_bit  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (bus.tec !== 9'd0) $display("FAIL reset_tec got %0d exp 0", bus.tec); else passes++;
        checks++; if (bus.rec !== 8'd0) $display("FAIL reset_rec got %0d exp 0", bus.rec); else passes++;
        checks++;
        if ({bus.node_error_passive, bus.node_bus_off, bus.error_warning, bus.state_change} !== 4'b0000)
            $display("FAIL reset_flags got %b exp 0000",
                     {bus.node_error_passive, bus.node_bus_off, bus.error_warning, bus.state_change});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passive();
        pulse(0, 0, 0, 0, 0, 1);
        tx_errors(15);
        checks++; if (bus.tec !== 9'd120 || bus.node_error_passive !== 1'b0)
            $display("FAIL passive_pre got tec=%0d ep=%b exp tec=120 ep=0", bus.tec, bus.node_error_passive); else passes++;
        tx_errors(1);
        checks++; if (bus.tec !== 9'd128 || bus.node_error_passive !== 1'b1 || bus.state_change !== 1'b1)
            $display("FAIL passive_enter got tec=%0d ep=%b sc=%b exp 128 1 1", bus.tec, bus.node_error_passive, bus.state_change); else passes++;
        tick();
        checks++; if (bus.state_change !== 1'b0)
            $display("FAIL passive_sc_width got %b exp 0", bus.state_change); else passes++;
        pulse(0, 1, 0, 0, 0, 0);
        checks++; if (bus.tec !== 9'd127 || bus.node_error_passive !== 1'b0 || bus.state_change !== 1'b1 || bus.error_warning !== 1'b1)
            $display("FAIL passive_exit got tec=%0d ep=%b sc=%b ew=%b exp 127 0 1 1", bus.tec, bus.node_error_passive, bus.state_change, bus.error_warning); else passes++;
    endtask

    task automatic test_bus_off();
        pulse(0, 0, 0, 0, 0, 1);
        tx_errors(32);
        checks++; if (bus.tec !== 9'd256 || bus.node_bus_off !== 1'b1 || bus.node_error_passive !== 1'b1 || bus.state_change !== 1'b1)
            $display("FAIL busoff_enter got tec=%0d bo=%b ep=%b sc=%b exp 256 1 1 1", bus.tec, bus.node_bus_off, bus.node_error_passive, bus.state_change); else passes++;
        pulse(1, 0, 1, 0, 0, 0);
        pulse(0, 1, 0, 1, 0, 0);
        checks++; if (bus.tec !== 9'd256 || bus.rec !== 8'd0)
            $display("FAIL busoff_ignore got tec=%0d rec=%0d exp 256 0", bus.tec, bus.rec); else passes++;
        samples(1407, 1'b1);
        checks++; if (bus.node_bus_off !== 1'b1)
            $display("FAIL busoff_early got bo=%b exp 1", bus.node_bus_off); else passes++;
        samples(1, 1'b1);
        checks++; if (bus.tec !== 9'd0 || bus.rec !== 8'd0 || bus.node_bus_off !== 1'b0 || bus.node_error_passive !== 1'b0 || bus.state_change !== 1'b1 || bus.error_warning !== 1'b0)
            $display("FAIL busoff_recover got tec=%0d rec=%0d bo=%b ep=%b sc=%b ew=%b exp 0 0 0 0 1 0",
                     bus.tec, bus.rec, bus.node_bus_off, bus.node_error_passive, bus.state_change, bus.error_warning); else passes++;
    endtask

    task automatic test_dominant_restart();
        pulse(0, 0, 0, 0, 0, 1);
        tx_errors(32);
        samples(44, 1'b1);
        samples(10, 1'b1);
        samples(1, 1'b0);
        samples(1363, 1'b1);
        checks++; if (bus.node_bus_off !== 1'b1)
            $display("FAIL dominant_early got bo=%b exp 1", bus.node_bus_off); else passes++;
        samples(1, 1'b1);
        checks++; if (bus.node_bus_off !== 1'b0 || bus.tec !== 9'd0)
            $display("FAIL dominant_recover got bo=%b tec=%0d exp 0 0", bus.node_bus_off, bus.tec); else passes++;
    endtask

    task automatic test_reset_mode_recovery();
        pulse(0, 0, 0, 0, 0, 1);
        tx_errors(32);
        samples(500, 1'b1);
        pulse(0, 0, 0, 0, 0, 1);
        checks++; if (bus.node_bus_off !== 1'b0 || bus.tec !== 9'd0 || bus.state_change !== 1'b1)
            $display("FAIL rm_recovery got bo=%b tec=%0d sc=%b exp 0 0 1", bus.node_bus_off, bus.tec, bus.state_change); else passes++;
        tx_errors(32);
        samples(1407, 1'b1);
        checks++; if (bus.node_bus_off !== 1'b1)
            $display("FAIL rm_counters_cleared got bo=%b exp 1", bus.node_bus_off); else passes++;
        samples(1, 1'b1);
        checks++; if (bus.node_bus_off !== 1'b0)
            $display("FAIL rm_second_recover got bo=%b exp 0", bus.node_bus_off); else passes++;
    endtask

    task automatic test_rec();
        pulse(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) pulse(0, 0, 0, 1, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        checks++; if (bus.rec !== 8'd130 || bus.node_error_passive !== 1'b1)
            $display("FAIL rec_130 got rec=%0d ep=%b exp 130 1", bus.rec, bus.node_error_passive); else passes++;
        pulse(0, 0, 0, 0, 1, 0);
        checks++; if (bus.rec !== 8'd119 || bus.node_error_passive !== 1'b0 || bus.state_change !== 1'b1)
            $display("FAIL rec_ok_high got rec=%0d ep=%b sc=%b exp 119 0 1", bus.rec, bus.node_error_passive, bus.state_change); else passes++;
        pulse(0, 0, 0, 0, 1, 0);
        checks++; if (bus.rec !== 8'd118)
            $display("FAIL rec_ok_dec got %0d exp 118", bus.rec); else passes++;
        pulse(0, 0, 0, 0, 0, 1);
        pulse(0, 0, 0, 0, 1, 0);
        checks++; if (bus.rec !== 8'd0)
            $display("FAIL rec_ok_zero got %0d exp 0", bus.rec); else passes++;
        for (int i = 0; i < 32; i++) pulse(0, 0, 0, 1, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        checks++; if (bus.rec !== 8'd255 || bus.node_bus_off !== 1'b0)
            $display("FAIL rec_saturate got rec=%0d bo=%b exp 255 0", bus.rec, bus.node_bus_off); else passes++;
    endtask

    task automatic test_same_cycle();
        pulse(0, 0, 0, 0, 0, 1);
        tx_errors(2);
        for (int i = 0; i < 6; i++) pulse(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0, 0, 0);
        checks++; if (bus.tec !== 9'd10 || bus.rec !== 8'd5)
            $display("FAIL same_setup got tec=%0d rec=%0d exp 10 5", bus.tec, bus.rec); else passes++;
        pulse(1, 1, 1, 1, 0, 0);
        checks++; if (bus.tec !== 9'd18 || bus.rec !== 8'd13)
            $display("FAIL same_priority got tec=%0d rec=%0d exp 18 13", bus.tec, bus.rec); else passes++;
        pulse(0, 0, 1, 0, 1, 0);
        checks++; if (bus.rec !== 8'd14)
            $display("FAIL same_rxerr_over_ok got %0d exp 14", bus.rec); else passes++;
    endtask

    task automatic test_warning();
        pulse(0, 0, 0, 0, 0, 1);
        tx_errors(11);
        checks++; if (bus.tec !== 9'd88 || bus.error_warning !== 1'b0)
            $display("FAIL warn_below got tec=%0d ew=%b exp 88 0", bus.tec, bus.error_warning); else passes++;
        tx_errors(1);
        checks++; if (bus.tec !== 9'd96 || bus.error_warning !== 1'b1)
            $display("FAIL warn_at got tec=%0d ew=%b exp 96 1", bus.tec, bus.error_warning); else passes++;
        pulse(0, 0, 0, 0, 0, 1);
        checks++; if (bus.tec !== 9'd0 || bus.error_warning !== 1'b0 || bus.node_error_passive !== 1'b0 || bus.state_change !== 1'b0)
            $display("FAIL warn_reset_mode got tec=%0d ew=%b ep=%b sc=%b exp 0 0 0 0", bus.tec, bus.error_warning, bus.node_error_passive, bus.state_change); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        bus.reset_mode   = 1'b0;
        bus.sample_point = 1'b0;
        bus.sampled_bit  = 1'b1;
        bus.tx_error     = 1'b0;
        bus.tx_ok        = 1'b0;
        bus.rx_error     = 1'b0;
        bus.rx_error_dom = 1'b0;
        bus.rx_ok        = 1'b0;
        test_reset();
        test_passive();
        test_bus_off();
        test_dominant_restart();
        test_reset_mode_recovery();
        test_rec();
        test_same_cycle();
        test_warning();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/can_fault_confinement.md
# can_fault_confinement

Fault-confinement block for the CAN Bus IP core. It keeps the Transmit Error Counter (TEC) and Receive Error Counter (REC) and tracks the node state: error-active, error-passive or bus-off. It also performs bus-off recovery by counting recessive bit sequences on the sampled bus. It sits downstream of the transmitter/receiver/timing stages, which supply error and success events plus the sampled bus bit. It feeds `node_error_passive` back into the core top level and the timing stage.

## Interface
Parameters:
- WARN_LIMIT, 96: error-warning threshold, applied to TEC and REC.
- PASSIVE_LIMIT, 127: counter value above which the node becomes error-passive.
- RECESSIVE_SEQ_LEN, 11: consecutive recessive bits that form one recovery sequence.
- RECOVERY_SEQ_CNT, 128: sequences required to leave bus-off.

Ports:
- clk  in  1  core clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- reset_mode  in  1  synchronous clear: counters to 0, state to ERROR_ACTIVE.
- sample_point  in  1  one-cycle strobe from the timing stage.
- sampled_bit  in  1  bus value at sample_point (1 = recessive).
- tx_error  in  1  pulse: transmitter detected an error; TEC +8.
- tx_ok  in  1  pulse: frame transmitted and acknowledged; TEC −1.
- rx_error  in  1  pulse: receiver detected an error; REC +1.
- rx_error_dom  in  1  pulse: receiver saw a dominant bit after its own error flag; REC +8.
- rx_ok  in  1  pulse: frame received correctly (rx_done_flag); REC decrement rule below.
- tec  out  9  transmit error counter.
- rec  out  8  receive error counter.
- node_error_passive  out  1  high in ERROR_PASSIVE and in BUS_OFF.
- node_bus_off  out  1  high in BUS_OFF.
- error_warning  out  1  high when tec ≥ WARN_LIMIT or rec ≥ WARN_LIMIT.
- state_change  out  1  one-cycle pulse whenever the node state changes.

## Operation
- States: ERROR_ACTIVE (00), ERROR_PASSIVE (01), BUS_OFF (10).
- Event priority within one cycle:
  - tx_error beats tx_ok.
  - For REC: rx_error_dom beats rx_error, which beats rx_ok. Only one REC rule applies per cycle.
  - TEC and REC events in the same cycle are applied independently.
- TEC arithmetic:
  - +8 saturates at 511.
  - −1 applies only when tec > 0.
- REC arithmetic:
  - +1 and +8 saturate at 255.
  - rx_ok with 1 ≤ rec ≤ 127: rec −1.
  - rx_ok with rec > 127: rec ← 119.
  - rx_ok with rec = 0: no change.
- State is computed from the next counter values:
  - next tec > 255 → BUS_OFF.
  - Otherwise, tec > PASSIVE_LIMIT or rec > PASSIVE_LIMIT → ERROR_PASSIVE.
  - Otherwise → ERROR_ACTIVE.
  - ERROR_PASSIVE returns to ERROR_ACTIVE as soon as both counters are ≤ PASSIVE_LIMIT.
- BUS_OFF behaviour:
  - All event inputs are ignored and tec/rec hold.
  - A 4-bit recessive-bit counter increments on each sample_point with sampled_bit = 1. It clears on sample_point with sampled_bit = 0.
  - When it reaches RECESSIVE_SEQ_LEN, it clears to 0 and the 8-bit sequence counter increments.
  - When the sequence counter reaches RECOVERY_SEQ_CNT: tec ← 0, rec ← 0, both recovery counters ← 0, state ← ERROR_ACTIVE.
- Recovery counters stay at 0 outside BUS_OFF.
- reset_mode has priority over all events and over recovery.

## Timing
- Reset values (rst_n low, asynchronous): tec = 0, rec = 0, state ERROR_ACTIVE, node_error_passive = 0, node_bus_off = 0, error_warning = 0, state_change = 0, recovery counters = 0.
- All outputs are registered. An event pulse in cycle N updates tec/rec, the state outputs and error_warning together at edge N+1, so there is no cycle in which counters and state disagree.
- state_change is high for exactly the cycle after the edge that changed the state. reset_mode forcing a state change also pulses it; asynchronous reset does not.
- Event inputs are single-cycle pulses. An input held high counts once per cycle.
- Recovery completes at the edge after the sample_point that ends sequence RECOVERY_SEQ_CNT. That is at least 128 × 11 = 1408 sample points after entering BUS_OFF.
- reset_mode asserted mid-recovery: recovery counters clear, state ERROR_ACTIVE the next cycle.

## Test plan
- After reset, 16 tx_error pulses → tec = 128, ERROR_PASSIVE on the 16th update, node_error_passive = 1, state_change pulse. Then 1 tx_ok → tec = 127, ERROR_ACTIVE, second state_change pulse.
- 32 tx_error pulses → tec = 256, node_bus_off = 1. Then tx_error/rx_error pulses → tec and rec unchanged. Then 1408 recessive sample points → tec = rec = 0, ERROR_ACTIVE.
- Bus-off recovery with a dominant sample inserted after 10 recessive bits in sequence 5 → that sequence restarts and recovery needs exactly 10 extra recessive samples.
- rec driven to 130 via rx_error_dom pulses, then rx_ok → rec = 119, ERROR_ACTIVE. rec = 0 with rx_ok → rec stays 0.
- Same-cycle tx_error + tx_ok with tec = 10 → tec = 18. Same-cycle rx_error + rx_error_dom with rec = 5 → rec = 13.
- 12 tx_error pulses → tec = 96, error_warning = 1. reset_mode pulse → tec = 0, error_warning = 0, state ERROR_ACTIVE.
